// File: rtl/alu_pkg.sv
// Shared ALU select encodings and datapath width, used by the arbiter and decode logic.
package alu_pkg;

  localparam int DATA_W = 32;

  typedef logic [3:0] alu_sel_t;

  localparam alu_sel_t ALU_ADD  = 4'b0000;
  localparam alu_sel_t ALU_SUB  = 4'b0001;
  localparam alu_sel_t ALU_SLL  = 4'b0100;
  localparam alu_sel_t ALU_SRL  = 4'b0101;
  localparam alu_sel_t ALU_SRA  = 4'b0110;
  localparam alu_sel_t ALU_AND  = 4'b1000;
  localparam alu_sel_t ALU_OR   = 4'b1001;
  localparam alu_sel_t ALU_XOR  = 4'b1010;
  localparam alu_sel_t ALU_LUI  = 4'b1100;
  localparam alu_sel_t ALU_SLTU = 4'b1101;
  localparam alu_sel_t ALU_SLT  = 4'b1110;

  // Signed overflow from operand/result sign bits; only add and sub can overflow.
  function automatic logic add_sub_ovf(alu_sel_t sel, logic a_msb, logic b_msb, logic r_msb);
    logic ovf;
    ovf = 1'b0;
    if (sel == ALU_ADD) ovf = (a_msb == b_msb) && (r_msb != a_msb);
    else if (sel == ALU_SUB) ovf = (a_msb != b_msb) && (r_msb != a_msb);
    return ovf;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; unknown select codes produce a zero result.
module alu
  import alu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_sel_t     sel,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         ovf
);

  localparam int SH_W = $clog2(W);

  logic [SH_W-1:0] shamt;

  assign shamt = b[SH_W-1:0];

  always_comb begin
    result = '0;
    case (sel)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = W'($signed(a) >>> shamt);
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_LUI:  result = b;
      ALU_SLTU: result = {{(W-1){1'b0}}, (a < b)};
      ALU_SLT:  result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign ovf  = add_sub_ovf(sel, a[W-1], b[W-1], result[W-1]);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters, with a one-entry
// registered result stage carrying its own valid/ready handshake.
module alu_share_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_a,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_b,
  input  logic [N_REQ-1:0][3:0]         req_sel,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_id,
  output logic [DATA_W-1:0]             rsp_result,
  output logic                          rsp_zero,
  output logic                          rsp_ovf
);

  import alu_pkg::*;

  logic              last_grant;
  logic              gnt_any;
  logic              gnt_idx;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  alu_sel_t          alu_sel;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovf;
  logic              alu_zero_unused;
  logic              alu_ovf_unused;

  // With nothing valid gnt_idx falls to 0, so the mux parks on requester 0.
  always_comb begin
    gnt_any    = req_valid[0] | req_valid[1];
    gnt_idx    = (req_valid[0] & req_valid[1]) ? ~last_grant : req_valid[1];
    can_accept = ~rsp_valid | rsp_ready;
    req_ready  = '0;
    if (gnt_any && can_accept && !rst) req_ready[gnt_idx] = 1'b1;
    accept     = |req_ready;
    alu_a      = req_a[gnt_idx];
    alu_b      = req_b[gnt_idx];
    alu_sel    = req_sel[gnt_idx];
    alu_ovf    = add_sub_ovf(alu_sel, alu_a[DATA_W-1], alu_b[DATA_W-1], alu_result[DATA_W-1]);
  end

  alu #(
    .W (DATA_W)
  ) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .sel    (alu_sel),
    .result (alu_result),
    .zero   (alu_zero_unused),
    .ovf    (alu_ovf_unused)
  );

  // Flags are derived here from the muxed operands rather than taken from the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= gnt_idx;
      rsp_result <= alu_result;
      rsp_zero   <= (alu_result == '0);
      rsp_ovf    <= alu_ovf;
      last_grant <= gnt_idx;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with hand-computed expectations.
module tb_alu_share_arbiter;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][3:0]  req_sel;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic             rsp_ovf;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(
    .N_REQ  (2),
    .DATA_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_ovf    (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    #3;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_result !== 32'd0 || rsp_zero !== 1'b0 || rsp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b id=%b r=%h z=%b o=%b expected all zero", rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ovf);
    end
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_req_ready: got %b expected 00", req_ready);
    end
    req_valid = 2'b00;
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    req_a[0] = 32'd5; req_b[0] = 32'd7; req_sel[0] = 4'b0000;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd12 || rsp_zero !== 1'b0 || rsp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: got v=%b id=%b r=%h z=%b o=%b expected v=1 id=0 r=0000000c z=0 o=0", rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ovf);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_retire: got rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic        exp_id;
    logic [31:0] exp_res;
    apply_reset();
    req_a[0] = 32'd1; req_b[0] = 32'd1; req_sel[0] = 4'b0000;
    req_a[1] = 32'd9; req_b[1] = 32'd9; req_sel[1] = 4'b0001;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id  = (i % 2 == 1);
      exp_rdy = exp_id ? 2'b10 : 2'b01;
      exp_res = exp_id ? 32'd0 : 32'd2;
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %b expected %b", i, req_ready, exp_rdy);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_result !== exp_res || rsp_zero !== (exp_res == 32'd0) || rsp_ovf !== 1'b0) begin
        errors++;
        $display("FAIL rr_rsp[%0d]: got v=%b id=%b r=%h z=%b o=%b expected v=1 id=%b r=%h z=%b o=0", i, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ovf, exp_id, exp_res, (exp_res == 32'd0));
      end
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_overflow();
    req_a[1] = 32'h7FFF_FFFF; req_b[1] = 32'd1; req_sel[1] = 4'b0000;
    req_valid = 2'b10;
    rsp_ready = 1'b1;
    step();
    checks++;
    if (rsp_id !== 1'b1 || rsp_result !== 32'h8000_0000 || rsp_ovf !== 1'b1 || rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL ovf_add: got id=%b r=%h o=%b z=%b expected id=1 r=80000000 o=1 z=0", rsp_id, rsp_result, rsp_ovf, rsp_zero);
    end
    req_a[1] = 32'h8000_0000; req_b[1] = 32'd1; req_sel[1] = 4'b0001;
    step();
    checks++;
    if (rsp_id !== 1'b1 || rsp_result !== 32'h7FFF_FFFF || rsp_ovf !== 1'b1 || rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL ovf_sub: got id=%b r=%h o=%b z=%b expected id=1 r=7fffffff o=1 z=0", rsp_id, rsp_result, rsp_ovf, rsp_zero);
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_backpressure();
    req_a[0] = 32'd10; req_b[0] = 32'd3; req_sel[0] = 4'b0000;
    req_a[1] = 32'd10; req_b[1] = 32'd3; req_sel[1] = 4'b0001;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_first_ready: got %b expected 01", req_ready);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_stall_ready[%0d]: got %b expected 00", i, req_ready);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd13) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%b r=%h expected v=1 id=0 r=0000000d", i, rsp_valid, rsp_id, rsp_result);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_release_ready: got %b expected 10", req_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd7) begin
      errors++;
      $display("FAIL bp_release_rsp: got v=%b id=%b r=%h expected v=1 id=1 r=00000007", rsp_valid, rsp_id, rsp_result);
    end
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_next_ready: got %b expected 01", req_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd13) begin
      errors++;
      $display("FAIL bp_next_rsp: got v=%b id=%b r=%h expected v=1 id=0 r=0000000d", rsp_valid, rsp_id, rsp_result);
    end
    req_valid = 2'b00;
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_ops();
    logic [3:0]  t_sel [12] = '{4'hF, 4'hE, 4'hD, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hC, 4'h2, 4'h1};
    logic [31:0] t_a   [12] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'h8000_0000, 32'h8000_0000,
                                32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0, 32'd99, 32'd5, 32'd5};
    logic [31:0] t_b   [12] = '{32'd4, 32'd1, 32'd1, 32'd4, 32'd4, 32'd4,
                                32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 32'h0000_1234, 32'd5, 32'd7};
    logic [31:0] t_exp [12] = '{32'd0, 32'd1, 32'd0, 32'h30, 32'h0800_0000, 32'hF800_0000,
                                32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFE};
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    for (int i = 0; i < 12; i++) begin
      req_a[0] = t_a[i]; req_b[0] = t_b[i]; req_sel[0] = t_sel[i];
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== t_exp[i] || rsp_zero !== (t_exp[i] == 32'd0) || rsp_ovf !== 1'b0) begin
        errors++;
        $display("FAIL op_sel_%h: got v=%b r=%h z=%b o=%b expected v=1 r=%h z=%b o=0", t_sel[i], rsp_valid, rsp_result, rsp_zero, rsp_ovf, t_exp[i], (t_exp[i] == 32'd0));
      end
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_reset_midstream();
    req_a[0] = 32'd1; req_b[0] = 32'd2; req_sel[0] = 4'b0000;
    req_a[1] = 32'd8; req_b[1] = 32'd2; req_sel[1] = 4'b0001;
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    step();
    req_valid = 2'b11;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd3 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL mid_setup: got v=%b r=%h rdy=%b expected v=1 r=00000003 rdy=00", rsp_valid, rsp_result, req_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: got v=%b r=%h rdy=%b expected v=0 r=00000000 rdy=00", rsp_valid, rsp_result, req_ready);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL mid_first_tie: got %b expected 01", req_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd3) begin
      errors++;
      $display("FAIL mid_after_rsp: got v=%b id=%b r=%h expected v=1 id=0 r=00000003", rsp_valid, rsp_id, rsp_result);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_ops();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
